// File: rtl/noc_pkg.sv
// noc_pkg: shared constants, state encoding and flit helpers for the B-tree NoC switch
package noc_pkg;
  localparam int NumPorts = 3;
  localparam int DefLastBit = 31;
  typedef enum logic {IDLE, LOCKED} arbStateT;
  function automatic int addrLsb(input int dataWidth, input int addrWidth);
    return dataWidth - addrWidth;
  endfunction
  // Offset compare stays correct when lo is 0 and the address is narrower than 32 bits
  function automatic logic inRange(input logic [31:0] addr, input logic [31:0] lo, input logic [31:0] hi);
    return (addr - lo) <= (hi - lo);
  endfunction
  function automatic logic [1:0] nextPort(input logic [1:0] p);
    return p == 2'(NumPorts - 1) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/noc_port_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker; ptr names the highest-priority port
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] grant
);
  logic [2:0] rot, pick;
  always_comb begin
    rot = ptr == 2'd1 ? {req[0], req[2:1]} : ptr == 2'd2 ? {req[1:0], req[2]} : req;
    pick = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
    grant = ptr == 2'd1 ? {pick[1:0], pick[2]} : ptr == 2'd2 ? {pick[0], pick[2:1]} : pick;
  end
endmodule

// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter: round-robin, packet-locking 3:1 arbiter with a registered output flit
module noc_port_arbiter
  import noc_pkg::*;
#(
  parameter int DataWidth = 36,
  parameter int AddrWidth = 4,
  parameter int MatchMin = 0,
  parameter int MatchMax = 0,
  parameter int LastBit = DefLastBit
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DataWidth-1:0] i_data0,
  input  logic [DataWidth-1:0] i_data1,
  input  logic [DataWidth-1:0] i_data2,
  input  logic                 i_data_valid0,
  input  logic                 i_data_valid1,
  input  logic                 i_data_valid2,
  output logic                 o_data_ready0,
  output logic                 o_data_ready1,
  output logic                 o_data_ready2,
  output logic [DataWidth-1:0] o_data,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic [2:0]           o_grant,
  output logic                 o_busy
);
  localparam int AddrLsb = addrLsb(DataWidth, AddrWidth);
  arbStateT state;
  logic [1:0] owner, ptr, accIdx;
  logic [DataWidth-1:0] data [NumPorts];
  logic [2:0] valid, match, req, grant, ready, acc, idleReady;
  logic space;
  assign data = '{i_data0, i_data1, i_data2};
  assign valid = {i_data_valid2, i_data_valid1, i_data_valid0};
  assign req = valid & match;
  // Each port's ready assumes it requests, so ready never depends on its own valid
  for (genvar n = 0; n < NumPorts; n++) begin : g_port
    logic [2:0] cand, candGrant;
    assign match[n] = inRange(32'(data[n][AddrLsb +: AddrWidth]), 32'(MatchMin), 32'(MatchMax));
    assign cand = (req & ~(3'b001 << n)) | (3'(match[n]) << n);
    rr_pick3 uCand (.req(cand), .ptr, .grant(candGrant));
    assign idleReady[n] = candGrant[n];
  end
  rr_pick3 uPick (.req, .ptr, .grant);
  assign space = !o_data_valid || i_data_ready;
  assign ready = (i_reset || !space) ? 3'b000 : state == LOCKED ? 3'b001 << owner : idleReady;
  assign acc = valid & ready;
  assign accIdx = acc[2] ? 2'd2 : acc[1] ? 2'd1 : 2'd0;
  assign {o_data_ready2, o_data_ready1, o_data_ready0} = ready;
  assign o_grant = i_reset ? 3'b000 : state == LOCKED ? 3'b001 << owner : grant;
  assign o_busy = state == LOCKED;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr <= 2'd0;
      o_data <= '0;
      o_data_valid <= 1'b0;
    end else if (|acc) begin
      o_data <= data[accIdx];
      o_data_valid <= 1'b1;
      if (data[accIdx][LastBit]) begin
        state <= IDLE;
        ptr <= nextPort(accIdx);
      end else if (state == IDLE) begin
        state <= LOCKED;
        owner <= accIdx;
      end
    end else if (i_data_ready) begin
      o_data_valid <= 1'b0;
    end
  end
endmodule
